// File: rtl/ks_serial_add_seq.sv
// rtl/ks_serial_add_seq.sv - multi-precision add/sub sequencer reusing one 8-bit Kogge-Stone adder
module kogge_stone_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [7:0] g0, p0, g1, p1, g2, p2, g3, p3;
  logic [8:0] c;

  // Prefix levels at distance 1, 2, 4; shifted-in (g=0, p=1) is the identity operator.
  always_comb begin
    g0 = a & b;
    p0 = a ^ b;
    g1 = g0 | (p0 & {g0[6:0], 1'b0});
    p1 = p0 & {p0[6:0], 1'b1};
    g2 = g1 | (p1 & {g1[5:0], 2'b00});
    p2 = p1 & {p1[5:0], 2'b11};
    g3 = g2 | (p2 & {g2[3:0], 4'h0});
    p3 = p2 & {p2[3:0], 4'hF};
    c  = {g3 | (p3 & {8{ci}}), ci};
    s  = p0 ^ c[7:0];
    co = c[8];
  end
endmodule

module ks_serial_add_seq #(
  parameter int NUM_SLICES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [8*NUM_SLICES-1:0] op_a,
  input  logic [8*NUM_SLICES-1:0] op_b,
  input  logic                    cin,
  input  logic                    sub,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [8*NUM_SLICES-1:0] result,
  output logic                    cout,
  output logic                    overflow,
  output logic                    busy
);
  localparam int W  = 8 * NUM_SLICES;
  localparam int IW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [W-1:0]  a_r, b_r;
  logic          carry_r;
  logic [IW-1:0] idx;
  logic [7:0]    slice_sum;
  logic          slice_co;
  logic          accept, last;

  assign accept = start_valid && start_ready;
  assign last   = (idx == IW'(NUM_SLICES - 1));

  kogge_stone_8 u_adder (
    .a  (a_r[8*idx +: 8]),
    .b  (b_r[8*idx +: 8]),
    .ci (carry_r),
    .s  (slice_sum),
    .co (slice_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + ~borrow, so B and the carry-in are inverted at capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      carry_r  <= 1'b0;
      idx      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_r     <= op_a;
      b_r     <= op_b ^ {W{sub}};
      carry_r <= cin ^ sub;
      idx     <= '0;
      result  <= '0;
    end else if (state == RUN) begin
      result[8*idx +: 8] <= slice_sum;
      carry_r            <= slice_co;
      if (last) begin
        cout     <= slice_co;
        overflow <= (a_r[W-1] == b_r[W-1]) && (slice_sum[7] != a_r[W-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ks_serial_add_seq.sv
// tb/tb_ks_serial_add_seq.sv - self-checking bench for ks_serial_add_seq with arithmetic reference model
module tb_ks_serial_add_seq;
  localparam int N = 4;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         rst, start_valid, start_ready, cin, sub;
  logic         res_valid, res_ready, cout, overflow, busy;
  logic [W-1:0] op_a, op_b, result;

  int checks = 0;
  int failures = 0;

  ks_serial_add_seq #(.NUM_SLICES(N)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .cout(cout), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic, cout = carry (add) or no-borrow (sub), overflow = signed range escape.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                input logic s, output logic [W-1:0] r, output logic co,
                                output logic ov);
    longint ua, ub, sa, sb, st, tot;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!s) begin
      tot = ua + ub + longint'(c);
      co  = tot[W];
      st  = sa + sb + longint'(c);
    end else begin
      tot = ua - ub - longint'(c);
      co  = (ua >= ub + longint'(c));
      st  = sa - sb - longint'(c);
    end
    r  = tot[W-1:0];
    ov = (st > (longint'(1) <<< (W-1)) - 1) || (st < -(longint'(1) <<< (W-1)));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, verify latency and busy/ready while running, then compare and drain.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s);
    logic [W-1:0] er;
    logic eco, eov;
    int n;
    bit bad_ctl;
    model(a, b, c, s, er, eco, eov);
    op_a = a; op_b = b; cin = c; sub = s; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    op_a = ~a; op_b = ~b; cin = ~c; sub = ~s;
    n = 0;
    bad_ctl = 1'b0;
    while (!res_valid && n < 100) begin
      if (start_ready !== 1'b0 || busy !== 1'b1) bad_ctl = 1'b1;
      step();
      n++;
    end
    checks++;
    if (n !== N) begin
      failures++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, n, N);
    end
    checks++;
    if (bad_ctl) begin
      failures++;
      $display("FAIL %s run_ctl: start_ready/busy wrong during RUN (got ready=%b busy=%b, expected 0/1)",
               name, start_ready, busy);
    end
    checks++;
    if (result !== er || cout !== eco || overflow !== eov) begin
      failures++;
      $display("FAIL %s result: got %h c=%b v=%b, expected %h c=%b v=%b",
               name, result, cout, overflow, er, eco, eov);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s drain: got valid=%b ready=%b busy=%b, expected 0/1/0",
               name, res_valid, start_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 ||
        result !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset: got ready=%b valid=%b busy=%b result=%h c=%b v=%b, expected 1/0/0/0/0/0",
               start_ready, res_valid, busy, result, cout, overflow);
    end
  endtask

  task automatic test_directed();
    run_op("add_ff_1",     32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    run_op("add_ripple",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    run_op("add_pos_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    run_op("add_neg_ovf",  32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("sub_5_7",      32'd5,        32'd7,        1'b0, 1'b1);
    run_op("sub_7_5",      32'd7,        32'd5,        1'b0, 1'b1);
    run_op("sub_7_5_brw",  32'd7,        32'd5,        1'b1, 1'b1);
    run_op("add_cin",      32'h0000FFFF, 32'h00000000, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] er, held;
    logic eco, eov;
    int n;
    op_a = 32'h01020304; op_b = 32'h10203040; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 100) begin step(); n++; end
    checks++;
    if (res_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_valid: got res_valid=%b, expected 1", res_valid);
    end
    held = result;
    for (int i = 0; i < 3; i++) begin
      op_a = $urandom; op_b = $urandom; cin = 1'($urandom); sub = 1'($urandom); start_valid = 1'b1;
      step();
      checks++;
      if (result !== held || start_ready !== 1'b0 || res_valid !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got result=%h ready=%b valid=%b busy=%b, expected %h/0/1/1",
                 i, result, start_ready, res_valid, busy, held);
      end
    end
    op_a = 32'hCAFEF00D; op_b = 32'h12345678; cin = 1'b1; sub = 1'b1;
    model(op_a, op_b, cin, sub, er, eco, eov);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || result !== held) begin
      failures++;
      $display("FAIL bp_idle: got ready=%b busy=%b result=%h, expected 1/0/%h",
               start_ready, busy, result, held);
    end
    step();
    start_valid = 1'b0;
    op_a = '0; op_b = '0;
    n = 0;
    while (!res_valid && n < 100) begin step(); n++; end
    checks++;
    if (n !== N || result !== er || cout !== eco || overflow !== eov) begin
      failures++;
      $display("FAIL bp_next: got lat=%0d %h c=%b v=%b, expected lat=%0d %h c=%b v=%b",
               n, result, cout, overflow, N, er, eco, eov);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    op_a = 32'hFFFFFFFF; op_b = 32'h00000001; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      failures++;
      $display("FAIL mid_reset: got ready=%b valid=%b busy=%b result=%h, expected 1/0/0/0",
               start_ready, res_valid, busy, result);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (res_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL mid_reset_ghost: got res_valid=1 after reset, expected 0");
    end
    run_op("post_reset", 32'h12345678, 32'h11111111, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
